cache_2way: RTL and testbench

Two-way set-associative, write-back, write-allocate data cache sitting between the pipelined MIPS core's memory stage and the 128-bit block memory. Next-generation replacement for the direct-mapped cache: same processor and memory handshakes, parametrised set count, true LRU replacement per set, and saturating hit/miss counters for performance measurement.

---
 rtl/cache_2way.sv | 188 ++++++++++++++++++
 tb/tb_cache_2way.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_2way.sv
// Two-way set-associative, write-back, write-allocate data cache with true LRU
// per set and saturating hit/miss counters, between the core and 128-bit block memory.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// COMPARE   | tag lookup; hits complete, misses pick and latch a victim
// WRITEBACK | dirty victim line being written to memory
// ALLOCATE  | fill line being read from memory into the victim way
module cache_2way #(
  parameter int SET_W = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             proc_reset,
  input  logic             proc_read,
  input  logic             proc_write,
  input  logic [29:0]      proc_addr,
  input  logic [31:0]      proc_wdata,
  output logic             proc_stall,
  output logic [31:0]      proc_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [27:0]      mem_addr,
  output logic [127:0]     mem_wdata,
  input  logic [127:0]     mem_rdata,
  input  logic             mem_ready,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int TAG_W = 28 - SET_W;
  localparam int SETS  = 1 << SET_W;

  typedef enum logic [1:0] {
    S_COMPARE   = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SETS-1:0]  valid_q [2];
  logic [SETS-1:0]  dirty_q [2];
  logic [TAG_W-1:0] tag_q   [2][SETS];
  logic [127:0]     data_q  [2][SETS];
  logic [SETS-1:0]  lru_q;
  logic             victim_q;

  logic [SET_W-1:0] set_idx;
  logic [TAG_W-1:0] tag_in;
  logic [6:0]       word_bit;
  logic             req;
  logic             hit0, hit1, hit, hit_way;
  logic             victim, victim_dirty;
  logic [127:0]     hit_line;
  logic             hit_evt, miss_evt, wb_evt, fill_evt;

  assign set_idx  = proc_addr[SET_W+1:2];
  assign tag_in   = proc_addr[29:SET_W+2];
  assign word_bit = {proc_addr[1:0], 5'b0};
  assign req      = proc_read | proc_write;

  assign hit0    = valid_q[0][set_idx] && (tag_q[0][set_idx] == tag_in);
  assign hit1    = valid_q[1][set_idx] && (tag_q[1][set_idx] == tag_in);
  assign hit     = req && (hit0 || hit1);
  assign hit_way = hit0 ? 1'b0 : 1'b1;

  assign hit_line   = data_q[hit_way][set_idx];
  assign proc_rdata = hit_line[word_bit +: 32];

  // Invalid ways are filled before anything resident is displaced.
  always_comb begin
    victim = lru_q[set_idx];
    if (!valid_q[0][set_idx])
      victim = 1'b0;
    else if (!valid_q[1][set_idx])
      victim = 1'b1;
  end

  assign victim_dirty = valid_q[victim][set_idx] && dirty_q[victim][set_idx];

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset)
      state_q <= S_COMPARE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    hit_evt    = 1'b0;
    miss_evt   = 1'b0;
    wb_evt     = 1'b0;
    fill_evt   = 1'b0;
    case (state_q)
      S_COMPARE: begin
        if (req) begin
          if (hit) begin
            hit_evt = 1'b1;
          end else begin
            miss_evt   = 1'b1;
            proc_stall = 1'b1;
            state_d    = victim_dirty ? S_WRITEBACK : S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        proc_stall = 1'b1;
        if (mem_ready) begin
          wb_evt  = 1'b1;
          state_d = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        proc_stall = 1'b1;
        if (mem_ready) begin
          fill_evt = 1'b1;
          state_d  = S_COMPARE;
        end
      end
      default: state_d = S_COMPARE;
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      victim_q  <= 1'b0;
      lru_q     <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      for (int w = 0; w < 2; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
        for (int s = 0; s < SETS; s++) begin
          tag_q[w][s]  <= '0;
          data_q[w][s] <= '0;
        end
      end
    end else begin
      if (hit_evt) begin
        if (proc_write) begin
          data_q[hit_way][set_idx][word_bit +: 32] <= proc_wdata;
          dirty_q[hit_way][set_idx]                <= 1'b1;
        end
        lru_q[set_idx] <= ~hit_way;
        if (hit_cnt != '1)
          hit_cnt <= hit_cnt + 1'b1;
      end

      if (miss_evt) begin
        victim_q <= victim;
        if (miss_cnt != '1)
          miss_cnt <= miss_cnt + 1'b1;
        if (victim_dirty) begin
          mem_write <= 1'b1;
          mem_addr  <= {tag_q[victim][set_idx], set_idx};
          mem_wdata <= data_q[victim][set_idx];
        end else begin
          mem_read <= 1'b1;
          mem_addr <= proc_addr[29:2];
        end
      end

      if (wb_evt) begin
        dirty_q[victim_q][set_idx] <= 1'b0;
        mem_write                  <= 1'b0;
        mem_read                   <= 1'b1;
        mem_addr                   <= proc_addr[29:2];
      end

      // Fill leaves the line clean; a retried write dirties it on the hit that follows.
      if (fill_evt) begin
        data_q[victim_q][set_idx]  <= mem_rdata;
        tag_q[victim_q][set_idx]   <= tag_in;
        valid_q[victim_q][set_idx] <= 1'b1;
        dirty_q[victim_q][set_idx] <= 1'b0;
        lru_q[set_idx]             <= ~victim_q;
        mem_read                   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cache_2way.sv
// Directed bench for cache_2way: a latency-2 block memory model answers fills and
// writebacks; expected data, stall lengths and counter values are hand-computed.
module tb_cache_2way;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             proc_reset;
  logic             proc_read, proc_write;
  logic [29:0]      proc_addr;
  logic [31:0]      proc_wdata;
  logic             proc_stall;
  logic [31:0]      proc_rdata;
  logic             mem_read, mem_write;
  logic [27:0]      mem_addr;
  logic [127:0]     mem_wdata;
  logic [127:0]     mem_rdata;
  logic             mem_ready;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  cache_2way #(.SET_W(2), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  logic [127:0] mem_model [64];
  int           rd_done = 0;
  int           wr_done = 0;
  int           lat = 0;
  logic         both_seen = 1'b0;
  logic [27:0]  last_waddr = '0;
  logic [127:0] last_wdata = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_hit_cnt"}, 128'(hit_cnt), 128'(exp_hit));
    chk({tag, "_miss_cnt"}, 128'(miss_cnt), 128'(exp_miss));
  endtask

  // Called just after a rising edge; returns read data and number of stalled cycles.
  task automatic access(input logic wr, input logic [29:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int cyc);
    logic done;
    proc_read  = ~wr;
    proc_write = wr;
    proc_addr  = addr;
    proc_wdata = wd;
    cyc  = 0;
    done = 1'b0;
    rd   = '0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!proc_stall) begin
        rd   = proc_rdata;
        done = 1'b1;
      end else begin
        cyc++;
        @(posedge clk);
        #1;
      end
    end
    if (!done) chk("access_timeout", 128'(0), 128'(1));
    @(posedge clk);
    #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    if (exp_hit < 7) exp_hit++;
    if (cyc > 0 && exp_miss < 7) exp_miss++;
  endtask

  // Block memory: answers the third falling edge of a request with a one-cycle ready.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    for (int b = 0; b < 64; b++)
      for (int w = 0; w < 4; w++)
        mem_model[b][32*w +: 32] = {16'(b), 16'(16'h1111 * (w + 1))};
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (proc_reset) begin
        lat = 0;
      end else if (mem_read || mem_write) begin
        if (mem_read && mem_write) both_seen = 1'b1;
        if (lat == 2) begin
          lat = 0;
          mem_ready = 1'b1;
          if (mem_write) begin
            mem_model[mem_addr[5:0]] = mem_wdata;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
            wr_done++;
          end else begin
            mem_rdata = mem_model[mem_addr[5:0]];
            rd_done++;
          end
        end else begin
          lat++;
        end
      end
    end
  end

  initial begin
    logic [31:0] rd;
    int cyc;
    int wr_snap;

    proc_reset = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 128'(proc_stall), 128'(0));
    chk("rst_mem_read", 128'(mem_read), 128'(0));
    chk("rst_mem_write", 128'(mem_write), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_mem_wdata", mem_wdata, 128'(0));
    chk_cnt("rst");
    proc_reset = 1'b0;
    @(posedge clk);
    #1;

    // Cold miss on block 4, then hits on the same line.
    access(1'b0, 30'h10, 32'h0, rd, cyc);
    chk("cold_stall", 128'(cyc), 128'(4));
    chk("cold_rdata", 128'(rd), 128'(32'h0004_1111));
    chk("cold_fills", 128'(rd_done), 128'(1));
    chk_cnt("cold");
    access(1'b0, 30'h11, 32'h0, rd, cyc);
    chk("rehit_stall", 128'(cyc), 128'(0));
    chk("rehit_rdata", 128'(rd), 128'(32'h0004_2222));
    chk_cnt("rehit");

    // Idle cycles leave the counters untouched.
    repeat (3) @(posedge clk);
    #1;
    chk_cnt("idle");

    // Second tag in set 0 fills the other way; alternating reads all hit.
    access(1'b0, 30'h00, 32'h0, rd, cyc);
    chk("tag0_stall", 128'(cyc), 128'(4));
    chk("tag0_rdata", 128'(rd), 128'(32'h0000_1111));
    access(1'b0, 30'h10, 32'h0, rd, cyc);
    chk("alt1_stall", 128'(cyc), 128'(0));
    access(1'b0, 30'h00, 32'h0, rd, cyc);
    chk("alt2_stall", 128'(cyc), 128'(0));
    access(1'b0, 30'h13, 32'h0, rd, cyc);
    chk("alt3_stall", 128'(cyc), 128'(0));
    chk("alt3_rdata", 128'(rd), 128'(32'h0004_4444));
    chk("alt_fills", 128'(rd_done), 128'(2));
    chk_cnt("alt");

    // Way 0 touched last, so tag 2 evicts way 1 (block 0); block 4 survives.
    access(1'b0, 30'h20, 32'h0, rd, cyc);
    chk("lru_stall", 128'(cyc), 128'(4));
    chk("lru_rdata", 128'(rd), 128'(32'h0008_1111));
    access(1'b0, 30'h10, 32'h0, rd, cyc);
    chk("lru_keep_stall", 128'(cyc), 128'(0));
    access(1'b0, 30'h00, 32'h0, rd, cyc);
    chk("lru_evicted_stall", 128'(cyc), 128'(4));
    chk("lru_no_wb", 128'(wr_done), 128'(0));

    // Dirty block 4 written back when block 8 displaces it.
    access(1'b1, 30'h12, 32'hDEAD_BEEF, rd, cyc);
    chk("wr_hit_stall", 128'(cyc), 128'(0));
    access(1'b0, 30'h00, 32'h0, rd, cyc);
    access(1'b0, 30'h20, 32'h0, rd, cyc);
    chk("wb_stall", 128'(cyc), 128'(7));
    chk("wb_rdata", 128'(rd), 128'(32'h0008_1111));
    chk("wb_count", 128'(wr_done), 128'(1));
    chk("wb_addr", 128'(last_waddr), 128'(28'h4));
    chk("wb_data", last_wdata, 128'h00044444_DEADBEEF_00042222_00041111);
    access(1'b0, 30'h12, 32'h0, rd, cyc);
    chk("wb_refill_stall", 128'(cyc), 128'(4));
    chk("wb_refill_rdata", 128'(rd), 128'(32'hDEAD_BEEF));
    chk_cnt("wb");

    // Write miss to clean set 1, read back, then prove dirty via writeback.
    access(1'b1, 30'h05, 32'hCAFE_0001, rd, cyc);
    chk("wmiss_stall", 128'(cyc), 128'(4));
    access(1'b0, 30'h05, 32'h0, rd, cyc);
    chk("wmiss_read_stall", 128'(cyc), 128'(0));
    chk("wmiss_read_rdata", 128'(rd), 128'(32'hCAFE_0001));
    access(1'b0, 30'h15, 32'h0, rd, cyc);
    chk("wmiss_fill2_stall", 128'(cyc), 128'(4));
    access(1'b0, 30'h25, 32'h0, rd, cyc);
    chk("wmiss_wb_stall", 128'(cyc), 128'(7));
    chk("wmiss_wb_rdata", 128'(rd), 128'(32'h0009_2222));
    chk("wmiss_wb_addr", 128'(last_waddr), 128'(28'h1));
    chk("wmiss_wb_data", last_wdata, 128'h00014444_00013333_CAFE0001_00011111);
    chk_cnt("sat");

    // Reset while a writeback of dirty block 8 is outstanding.
    access(1'b1, 30'h20, 32'h1234_5678, rd, cyc);
    access(1'b0, 30'h12, 32'h0, rd, cyc);
    wr_snap = wr_done;
    proc_read = 1'b1;
    proc_addr = 30'h30;
    @(posedge clk);
    #1;
    chk("mid_wb_write", 128'(mem_write), 128'(1));
    chk("mid_wb_read", 128'(mem_read), 128'(0));
    chk("mid_wb_addr", 128'(mem_addr), 128'(28'h8));
    proc_reset = 1'b1;
    #1;
    chk("async_write", 128'(mem_write), 128'(0));
    chk("async_addr", 128'(mem_addr), 128'(0));
    chk("async_stall_req", 128'(proc_stall), 128'(1));
    exp_hit  = 0;
    exp_miss = 0;
    chk_cnt("async");
    proc_read = 1'b0;
    #1;
    chk("async_stall_idle", 128'(proc_stall), 128'(0));
    @(posedge clk);
    #1;
    proc_reset = 1'b0;
    @(posedge clk);
    #1;
    access(1'b0, 30'h10, 32'h0, rd, cyc);
    chk("post_rst_stall", 128'(cyc), 128'(4));
    chk("post_rst_rdata", 128'(rd), 128'(32'h0004_1111));
    chk("post_rst_no_wb", 128'(wr_done), 128'(wr_snap));
    chk_cnt("post_rst");

    chk("never_both", 128'(both_seen), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
